// File: rtl/argmax_unit.sv
`default_nettype none
// ============================================================================
//  Module      : argmax_unit
//  Description : Output stage of the neural network. On a rising edge of
//                start it reads NUM_CLASSES signed scores from the score
//                memory, one per cycle. It then publishes the index and value
//                of the largest score together with a one-cycle done pulse.
//  Revision    : 1.0  initial release
// ============================================================================
module argmax_unit #(
   parameter int NUM_CLASSES = 10,
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  busy,
   output logic                  done,
   output logic [3:0]            argmax_output,
   output logic [DATA_WIDTH-1:0] max_value
);

   // State encoding
   localparam logic [1:0] c_idle  = 2'd0;
   localparam logic [1:0] c_scan  = 2'd1;
   localparam logic [1:0] c_drain = 2'd2;
   localparam logic [1:0] c_done  = 2'd3;

   // Last address issued during a scan, and the "no result" display code
   localparam logic [ADDR_WIDTH-1:0] c_last  = ADDR_WIDTH'(NUM_CLASSES - 1);
   localparam logic [ADDR_WIDTH-1:0] c_first = '0;
   localparam logic [3:0]            c_blank = 4'd10;

   logic [1:0]            r_state;
   logic [1:0]            w_state_next;
   logic                  r_start_q;
   logic                  w_trigger;
   logic                  w_accept;
   logic [ADDR_WIDTH-1:0] r_cnt;

   // Read-return tracking: one cycle behind the address bus
   logic                  r_cmp_vld;
   logic [ADDR_WIDTH-1:0] r_cmp_idx;

   // Running best (working registers, never visible on the ports)
   logic [DATA_WIDTH-1:0] r_best_val;
   logic [ADDR_WIDTH-1:0] r_best_idx;

   // Best after folding in the datum currently on rd_data
   logic                  w_take;
   logic [DATA_WIDTH-1:0] w_next_val;
   logic [ADDR_WIDTH-1:0] w_next_idx;

   // Rising-edge detect on the level start request
   assign w_trigger = start & ~r_start_q;
   assign w_accept  = (r_state == c_idle) && w_trigger;

   // Start edge register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_start_q <= 1'b0;
      end else begin
         r_start_q <= start;
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= c_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic; triggers outside IDLE are simply ignored
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_idle:  if (w_trigger) w_state_next = c_scan;
         c_scan:  if (r_cnt == c_last) w_state_next = c_drain;
         c_drain: w_state_next = c_done;
         c_done:  w_state_next = c_idle;
         default: w_state_next = c_idle;
      endcase
   end

   // Output decode from state; rd_addr follows the counter so it holds when idle
   always_comb begin
      rd_en   = 1'b0;
      busy    = 1'b0;
      done    = 1'b0;
      rd_addr = r_cnt;
      case (r_state)
         c_idle:  busy = 1'b0;
         c_scan:  begin
            rd_en = 1'b1;
            busy  = 1'b1;
         end
         c_drain: busy = 1'b1;
         c_done:  begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: busy = 1'b0;
      endcase
   end

   // Address counter: cleared on accept, advances through the scan, parks on the last address
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (w_accept) begin
         r_cnt <= '0;
      end else if ((r_state == c_scan) && (r_cnt != c_last)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Delay the read strobe and address by the memory latency to tag returning data
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cmp_vld <= 1'b0;
         r_cmp_idx <= '0;
      end else begin
         r_cmp_vld <= rd_en;
         r_cmp_idx <= rd_addr;
      end
   end

   // Address 0 seeds the best unconditionally; later scores must be strictly greater
   always_comb begin
      w_take     = 1'b0;
      w_next_val = r_best_val;
      w_next_idx = r_best_idx;
      if (r_cmp_vld) begin
         if (r_cmp_idx == c_first) begin
            w_take = 1'b1;
         end else if ($signed(rd_data) > $signed(r_best_val)) begin
            w_take = 1'b1;
         end
      end
      if (w_take) begin
         w_next_val = rd_data;
         w_next_idx = r_cmp_idx;
      end
   end

   // Running best registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_best_val <= '0;
         r_best_idx <= '0;
      end else if (w_take) begin
         r_best_val <= w_next_val;
         r_best_idx <= w_next_idx;
      end
   end

   // Publish the result on the edge that leaves DRAIN, which also absorbs the final datum
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         argmax_output <= c_blank;
         max_value     <= '0;
      end else if (r_state == c_drain) begin
         argmax_output <= 4'(w_next_idx);
         max_value     <= w_next_val;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_argmax_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_argmax_unit
//  Description : Directed self-checking bench for argmax_unit with a
//                one-cycle-latency score memory model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_argmax_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic        rd_en;
   logic [3:0]  rd_addr;
   logic [31:0] rd_data;
   logic        busy;
   logic        done;
   logic [3:0]  argmax_output;
   logic [31:0] max_value;

   logic [31:0] mem [0:15];

   int total = 0;
   int bad   = 0;

   int done_cnt = 0;
   int rden_cnt = 0;
   int addr_err = 0;
   int chg_err  = 0;
   logic [3:0] prev_arg;

   argmax_unit #(
      .NUM_CLASSES(10),
      .DATA_WIDTH (32),
      .ADDR_WIDTH (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .rd_en        (rd_en),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .busy         (busy),
      .done         (done),
      .argmax_output(argmax_output),
      .max_value    (max_value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Score memory: data for the address presented in one cycle appears in the next
   initial rd_data = '0;
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   // Bus monitor: counts done pulses and reads, flags illegal addresses and result changes off the done edge
   always @(negedge clk) begin
      if (done) done_cnt++;
      if (rd_en) begin
         rden_cnt++;
         if (rd_addr >= 4'd10) addr_err++;
      end
      if (reset) begin
         prev_arg = argmax_output;
      end else begin
         if ((argmax_output !== prev_arg) && !done) chg_err++;
         prev_arg = argmax_output;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic load(input int v0, input int v1, input int v2, input int v3, input int v4,
                       input int v5, input int v6, input int v7, input int v8, input int v9);
      mem[0] = 32'(v0); mem[1] = 32'(v1); mem[2] = 32'(v2); mem[3] = 32'(v3); mem[4] = 32'(v4);
      mem[5] = 32'(v5); mem[6] = 32'(v6); mem[7] = 32'(v7); mem[8] = 32'(v8); mem[9] = 32'(v9);
   endtask

   // One-cycle start pulse; returns the index of the edge (E0 = accept) after which done is seen
   task automatic start_and_wait(output int done_edge);
      done_edge = -1;
      @(negedge clk);
      start = 1'b1;
      for (int e = 0; e < 40; e++) begin
         @(negedge clk);
         if (e == 0) start = 1'b0;
         if (done) begin
            done_edge = e;
            break;
         end
      end
   endtask

   int de;
   int d0;
   int r0;
   logic held2;
   logic got_done;

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_rd_en",  {31'd0, rd_en}, 32'd0);
      chk("rst_rd_addr", {28'd0, rd_addr}, 32'd0);
      chk("rst_busy",   {31'd0, busy}, 32'd0);
      chk("rst_done",   {31'd0, done}, 32'd0);
      chk("rst_argmax", {28'd0, argmax_output}, 32'd10);
      chk("rst_maxval", max_value, 32'd0);
      #2 reset = 1'b0;
      repeat (2) @(negedge clk);

      // 1: max at last index, latency from accept to done
      load(3, 1, 4, 1, 5, 9, 2, 6, 5, 30);
      d0 = done_cnt;
      r0 = rden_cnt;
      start_and_wait(de);
      chk("t1_done_edge", 32'(de), 32'd11);
      chk("t1_argmax", {28'd0, argmax_output}, 32'd9);
      chk("t1_maxval", max_value, 32'd30);
      repeat (3) @(negedge clk);
      chk("t1_done_cnt", 32'(done_cnt - d0), 32'd1);
      chk("t1_reads", 32'(rden_cnt - r0), 32'd10);

      // 2: all equal, lowest index wins
      load(7, 7, 7, 7, 7, 7, 7, 7, 7, 7);
      d0 = done_cnt;
      start_and_wait(de);
      chk("t2_argmax", {28'd0, argmax_output}, 32'd0);
      chk("t2_maxval", max_value, 32'd7);
      @(negedge clk);
      chk("t2_busy_after", {31'd0, busy}, 32'd0);
      chk("t2_done_after", {31'd0, done}, 32'd0);
      repeat (3) @(negedge clk);
      chk("t2_done_cnt", 32'(done_cnt - d0), 32'd1);

      // 3: all negative
      load(-100, -100, -100, -100, -100, -100, -5, -100, -100, -100);
      start_and_wait(de);
      chk("t3_argmax", {28'd0, argmax_output}, 32'd6);
      chk("t3_maxval", max_value, 32'hFFFF_FFFB);
      repeat (2) @(negedge clk);

      // 4: reset while reading address 4 aborts without a result
      load(3, 1, 4, 1, 5, 9, 2, 6, 5, 30);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (rd_en && (rd_addr == 4'd4)) break;
         @(negedge clk);
      end
      chk("t4_at_addr4", {27'd0, rd_en, rd_addr}, 32'h14);
      d0 = done_cnt;
      #2 reset = 1'b1;
      #1;
      chk("t4_rst_rd_en", {31'd0, rd_en}, 32'd0);
      chk("t4_rst_busy", {31'd0, busy}, 32'd0);
      chk("t4_rst_argmax", {28'd0, argmax_output}, 32'd10);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      repeat (15) @(negedge clk);
      chk("t4_no_done", 32'(done_cnt - d0), 32'd0);
      chk("t4_still_blank", {28'd0, argmax_output}, 32'd10);
      start_and_wait(de);
      chk("t4_rerun_edge", 32'(de), 32'd11);
      chk("t4_rerun_argmax", {28'd0, argmax_output}, 32'd9);
      chk("t4_rerun_maxval", max_value, 32'd30);
      repeat (2) @(negedge clk);

      // 5: held start gives one run; a re-rise while busy is dropped
      load(1, 2, 3, 4, 50, 6, 7, 8, 9, 10);
      d0 = done_cnt;
      r0 = rden_cnt;
      @(negedge clk);
      start = 1'b1;
      repeat (40) @(negedge clk);
      start = 1'b0;
      repeat (5) @(negedge clk);
      chk("t5_hold_done", 32'(done_cnt - d0), 32'd1);
      chk("t5_hold_reads", 32'(rden_cnt - r0), 32'd10);
      chk("t5_hold_argmax", {28'd0, argmax_output}, 32'd4);
      d0 = done_cnt;
      r0 = rden_cnt;
      start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (25) @(negedge clk);
      chk("t5_rerise_done", 32'(done_cnt - d0), 32'd1);
      chk("t5_rerise_reads", 32'(rden_cnt - r0), 32'd10);

      // 6: back-to-back runs; result holds through the second scan
      load(1, 2, 50, 3, 4, 5, 6, 7, 8, 9);
      start_and_wait(de);
      chk("t6a_argmax", {28'd0, argmax_output}, 32'd2);
      chk("t6a_maxval", max_value, 32'd50);
      load(0, 0, 0, 0, 0, 0, 0, 0, 99, 0);
      held2    = 1'b1;
      got_done = 1'b0;
      @(negedge clk);
      start = 1'b1;
      for (int e = 0; e < 40; e++) begin
         @(negedge clk);
         if (e == 0) start = 1'b0;
         if (done) begin
            got_done = 1'b1;
            break;
         end
         if (argmax_output !== 4'd2) held2 = 1'b0;
      end
      chk("t6_got_done", {31'd0, got_done}, 32'd1);
      chk("t6_held_during_scan", {31'd0, held2}, 32'd1);
      chk("t6b_argmax", {28'd0, argmax_output}, 32'd8);
      chk("t6b_maxval", max_value, 32'd99);
      repeat (3) @(negedge clk);

      // Whole-run bus and output-stability properties
      chk("addr_range", 32'(addr_err), 32'd0);
      chk("result_stable", 32'(chg_err), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
